alu_issue_ctrl: RTL and testbench

- Sequential front end that drives the 16-bit combinational ALU (`my_ALU`) and consumes its outputs.
- Accepts encoded instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Presents operands to the ALU, captures `outW`/`zer`/`neg`, writes the result back, and reports it on a result port.
- Provides the stateful control, operand storage and flag register that the stateless ALU lacks.

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Sequential issue controller for the stateless 16-bit combinational ALU.
// It accepts one encoded instruction at a time and reads both operands from
// an internal 8-entry register file. It drives the ALU from registered
// outputs, then captures the ALU result and flags one cycle later. The
// result is written back to the register file and reported on a pulsed
// result port.
//
// Instruction word: [15:13] opc, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] cin,
//                   [2:0] reserved (ignored).
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   instr_valid / instr_ready     instruction handshake (accept = both high at an edge)
//   instr                         encoded instruction
//   ld_en / ld_addr / ld_data     direct register-file write port (any state)
//   alu_inA / alu_inB / alu_inC   registered operands and carry to the ALU
//   alu_opc                       registered opcode to the ALU
//   alu_outW / alu_zer / alu_neg  ALU result and flags
//   res_valid                     one-cycle pulse, result fields valid
//   res_data / res_rd             captured result and its destination register
//   flag_z / flag_n               sticky flags from the last completed op
module alu_issue_ctrl #(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  input  logic         ld_en,
  input  logic [2:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  output logic [W-1:0] alu_inA,
  output logic [W-1:0] alu_inB,
  output logic         alu_inC,
  output logic [2:0]   alu_opc,
  input  logic [W-1:0] alu_outW,
  input  logic         alu_zer,
  input  logic         alu_neg,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_rd,
  output logic         flag_z,
  output logic         flag_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [W-1:0] regs_r [NREG];
  logic [2:0]   rd_r;

  // Instruction field decode
  logic [2:0] opc_s;
  logic [2:0] rd_s;
  logic [2:0] rs1_s;
  logic [2:0] rs2_s;
  logic       cin_s;
  logic       unused_rsv_s;

  assign opc_s = instr[15:13];
  assign rd_s  = instr[12:10];
  assign rs1_s = instr[9:7];
  assign rs2_s = instr[6:4];
  assign cin_s = instr[3];
  // Reserved bits carry no meaning; folded here only so they are consumed.
  assign unused_rsv_s = ^instr[2:0];

  // Ready only in IDLE and never while reset is being applied, so the first
  // accept can happen in the cycle right after reset drops.
  assign instr_ready = (state_r == IDLE) && !rst;

  // Issue FSM, register file, ALU-driving registers and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {W{1'b0}};
      end
      rd_r      <= 3'd0;
      alu_inA   <= {W{1'b0}};
      alu_inB   <= {W{1'b0}};
      alu_inC   <= 1'b0;
      alu_opc   <= 3'd0;
      res_valid <= 1'b0;
      res_data  <= {W{1'b0}};
      res_rd    <= 3'd0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
    end else begin
      // Direct load first; an ALU writeback later in this block to the same
      // entry overrides it, which gives the writeback priority.
      if (ld_en) begin
        regs_r[ld_addr] <= ld_data;
      end
      case (state_r)
        IDLE: begin
          res_valid <= 1'b0;
          if (instr_valid) begin
            // Operands come from pre-edge contents, so a same-edge load to
            // rs1/rs2 is not visible to this instruction.
            alu_inA <= regs_r[rs1_s];
            alu_inB <= regs_r[rs2_s];
            alu_inC <= cin_s;
            alu_opc <= opc_s;
            rd_r    <= rd_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_data     <= alu_outW;
          res_rd       <= rd_r;
          flag_z       <= alu_zer;
          flag_n       <= alu_neg;
          regs_r[rd_r] <= alu_outW;
          res_valid    <= 1'b1;
          state_r      <= DONE;
        end
        DONE: begin
          res_valid <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl. A behavioural model of the 16-bit
// combinational ALU closes the loop around the controller.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic        alu_inC;
  logic [2:0]  alu_opc;
  logic [15:0] alu_outW;
  logic        alu_zer;
  logic        alu_neg;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        flag_z;
  logic        flag_n;

  int checks;
  int failures;

  alu_issue_ctrl #(.NREG(8), .W(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external combinational ALU
  always_comb begin
    case (alu_opc)
      3'b000:  alu_outW = 16'd0 - alu_inA;
      3'b001:  alu_outW = alu_inA + 16'd1;
      3'b010:  alu_outW = alu_inA + alu_inB + {15'd0, alu_inC};
      3'b011:  alu_outW = alu_inA + (alu_inB >> 1);
      3'b100:  alu_outW = alu_inA & alu_inB;
      3'b101:  alu_outW = alu_inA | alu_inB;
      3'b110:  alu_outW = {alu_inA[7:0], alu_inB[7:0]};
      default: alu_outW = 16'd0;
    endcase
    alu_zer = (alu_outW == 16'd0);
    alu_neg = alu_outW[15];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
  endtask

  // Waits (bounded) for ready, then presents the instruction for one accept edge.
  task automatic accept(input logic [2:0] opc, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic cin, input logic [2:0] rsv);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick;
      n++;
    end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout instr_ready=%b required=1", instr_ready);
    end
    instr = {opc, rd, rs1, rs2, cin, rsv};
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({instr_ready, res_valid, res_data, res_rd, flag_z, flag_n} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h rrd=%h z=%b n=%b required all 0",
               instr_ready, res_valid, res_data, res_rd, flag_z, flag_n);
    end
    checks++;
    if ({alu_inA, alu_inB, alu_inC, alu_opc} !== 36'd0) begin
      failures++;
      $display("FAIL reset_alu_drive got A=%h B=%h C=%b opc=%h required 0", alu_inA, alu_inB, alu_inC, alu_opc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got=%b required=1", instr_ready);
    end
  endtask

  task automatic test_add;
    load(3'd1, 16'h1234);
    load(3'd2, 16'h00F0);
    accept(3'b010, 3'd3, 3'd1, 3'd2, 1'b1, 3'b000);
    // EXEC cycle: operands on ALU, no result yet, not ready
    checks++;
    if ({alu_inA, alu_inB, alu_inC, alu_opc} !== {16'h1234, 16'h00F0, 1'b1, 3'b010}) begin
      failures++;
      $display("FAIL add_drive got A=%h B=%h C=%b opc=%h required 1234 00f0 1 2", alu_inA, alu_inB, alu_inC, alu_opc);
    end
    checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_exec_cycle got rv=%b rdy=%b required 0 0", res_valid, instr_ready);
    end
    tick;
    checks++;
    if ({res_valid, res_data, res_rd, flag_z, flag_n, instr_ready} !== {1'b1, 16'h1325, 3'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_result got rv=%b d=%h rd=%0d z=%b n=%b rdy=%b required 1 1325 3 0 0 0",
               res_valid, res_data, res_rd, flag_z, flag_n, instr_ready);
    end
    tick;
    checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1 || alu_inA !== 16'h1234) begin
      failures++;
      $display("FAIL add_pulse_end got rv=%b rdy=%b A=%h required 0 1 1234", res_valid, instr_ready, alu_inA);
    end
    // Read r3 back as an operand
    accept(3'b101, 3'd0, 3'd3, 3'd0, 1'b0, 3'b000);
    checks++;
    if (alu_inA !== 16'h1325) begin
      failures++;
      $display("FAIL add_readback got=%h required=1325", alu_inA);
    end
    tick;
    tick;
  endtask

  task automatic test_negate;
    load(3'd4, 16'h0001);
    accept(3'b000, 3'd5, 3'd4, 3'd0, 1'b0, 3'b000);
    tick;
    checks++;
    if ({res_valid, res_data, res_rd, flag_n, flag_z} !== {1'b1, 16'hFFFF, 3'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL negate got rv=%b d=%h rd=%0d n=%b z=%b required 1 ffff 5 1 0",
               res_valid, res_data, res_rd, flag_n, flag_z);
    end
    tick;
  endtask

  task automatic test_logic_pack;
    load(3'd1, 16'h0F00);
    load(3'd2, 16'h00F0);
    accept(3'b100, 3'd6, 3'd1, 3'd2, 1'b0, 3'b000);
    tick;
    checks++;
    if ({res_data, flag_z, flag_n} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL and_zero got d=%h z=%b n=%b required 0000 1 0", res_data, flag_z, flag_n);
    end
    tick;
    // Flags stay sticky in IDLE
    checks++;
    if (flag_z !== 1'b1) begin
      failures++;
      $display("FAIL flag_sticky got z=%b required=1", flag_z);
    end
    accept(3'b110, 3'd6, 3'd1, 3'd2, 1'b0, 3'b000);
    tick;
    checks++;
    if ({res_data, flag_z, flag_n} !== {16'h00F0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL pack got d=%h z=%b n=%b required 00f0 0 0", res_data, flag_z, flag_n);
    end
    tick;
  endtask

  task automatic test_wb_priority;
    load(3'd7, 16'hFFFF);
    accept(3'b001, 3'd7, 3'd7, 3'd0, 1'b0, 3'b000);
    // Load to r7 on the writeback edge: the ALU writeback must win
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hAAAA;
    tick;
    ld_en = 1'b0;
    checks++;
    if ({res_data, flag_z} !== {16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL inc_wrap got d=%h z=%b required 0000 1", res_data, flag_z);
    end
    tick;
    accept(3'b101, 3'd0, 3'd7, 3'd0, 1'b0, 3'b000);
    checks++;
    if (alu_inA !== 16'h0000) begin
      failures++;
      $display("FAIL wb_priority got r7=%h required=0000", alu_inA);
    end
    tick;
    tick;
  endtask

  task automatic test_ordering;
    // r1=0x0F00. Same-edge load to r1 at accept is not seen; rs1==rs2;
    // reserved bits set; cin driven even though opc 011 ignores it.
    accept(3'b011, 3'd2, 3'd1, 3'd1, 1'b1, 3'b111);
    checks++;
    if ({alu_inA, alu_inB, alu_inC, alu_opc} !== {16'h0F00, 16'h0F00, 1'b1, 3'b011}) begin
      failures++;
      $display("FAIL same_src got A=%h B=%h C=%b opc=%h required 0f00 0f00 1 3", alu_inA, alu_inB, alu_inC, alu_opc);
    end
    tick;
    checks++;
    if ({res_valid, res_data, res_rd} !== {1'b1, 16'h1680, 3'd2}) begin
      failures++;
      $display("FAIL half_add got rv=%b d=%h rd=%0d required 1 1680 2", res_valid, res_data, res_rd);
    end
    tick;
    // Same-edge load at the accept edge: operand uses old value, load still lands
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hBEEF;
    accept(3'b101, 3'd0, 3'd1, 3'd0, 1'b0, 3'b000);
    ld_en = 1'b0;
    checks++;
    if (alu_inA !== 16'h0F00) begin
      failures++;
      $display("FAIL ld_same_edge got A=%h required=0f00", alu_inA);
    end
    tick;
    tick;
    accept(3'b101, 3'd0, 3'd1, 3'd0, 1'b0, 3'b000);
    checks++;
    if (alu_inA !== 16'hBEEF) begin
      failures++;
      $display("FAIL ld_landed got A=%h required=beef", alu_inA);
    end
    tick;
    tick;
  endtask

  task automatic test_back_to_back;
    int acc_cyc [2];
    logic [15:0] pdata [2];
    int acc_n;
    int pulses;
    logic acc;
    acc_n = 0; pulses = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    pdata[0] = 16'hDEAD; pdata[1] = 16'hDEAD;
    instr = {3'b101, 3'd1, 3'd3, 3'd4, 1'b0, 3'b000};  // r3|r4 = 0x1325
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      acc = instr_ready && instr_valid;
      tick;
      if (acc) begin
        if (acc_n < 2) acc_cyc[acc_n] = c;
        acc_n++;
        if (acc_n == 1) instr = {3'b111, 3'd2, 3'd3, 3'd4, 1'b0, 3'b000};
        else instr_valid = 1'b0;
      end
      if (res_valid) begin
        if (pulses < 2) pdata[pulses] = res_data;
        pulses++;
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (acc_n !== 2 || (acc_cyc[1] - acc_cyc[0]) !== 3) begin
      failures++;
      $display("FAIL b2b_accepts got n=%0d gap=%0d required 2 3", acc_n, acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (pulses !== 2 || pdata[0] !== 16'h1325 || pdata[1] !== 16'h0000 || flag_z !== 1'b1) begin
      failures++;
      $display("FAIL b2b_results got pulses=%0d d0=%h d1=%h z=%b required 2 1325 0000 1",
               pulses, pdata[0], pdata[1], flag_z);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    seen = 0;
    accept(3'b001, 3'd5, 3'd4, 3'd0, 1'b0, 3'b000);
    rst = 1'b1;
    tick;
    if (res_valid) seen++;
    checks++;
    if ({instr_ready, alu_inA, alu_inB, alu_inC, alu_opc, res_valid, res_data, res_rd, flag_z, flag_n} !== 60'd0) begin
      failures++;
      $display("FAIL midop_reset got rdy=%b A=%h B=%h C=%b opc=%h rv=%b d=%h rd=%0d z=%b n=%b required all 0",
               instr_ready, alu_inA, alu_inB, alu_inC, alu_opc, res_valid, res_data, res_rd, flag_z, flag_n);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_ready got=%b required=1", instr_ready);
    end
    tick;
    if (res_valid) seen++;
    tick;
    if (res_valid) seen++;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midop_no_pulse got pulses=%0d required=0", seen);
    end
    // Destination r5 must read 0
    accept(3'b101, 3'd0, 3'd5, 3'd0, 1'b0, 3'b000);
    checks++;
    if (alu_inA !== 16'h0000) begin
      failures++;
      $display("FAIL midop_rd got r5=%h required=0000", alu_inA);
    end
    tick;
    tick;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'd0;
    test_reset;
    test_add;
    test_negate;
    test_logic_pack;
    test_wb_priority;
    test_ordering;
    test_back_to_back;
    test_reset_mid_op;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
